argmax_sequencer: RTL

//  Sequences the 10-class argmax comparator at the output of the TCB NN.

---
 rtl/argmax_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/argmax_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : argmax_sequencer
// Description : Collects NUM_CLASS serial class scores into the comparator's
//               packed layer_out bus. It then launches the argmax comparator
//               with a one-cycle cmp_valid, waits (bounded) for its result,
//               and holds the predicted class until the consumer takes it.
// Revision    : 1.0 - initial release
// ============================================================================
module argmax_sequencer #(
  parameter int DATA_WIDTH = 29,
  parameter int NUM_CLASS  = 10,
  parameter int TIMEOUT    = 15
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            abort,
  input  logic                            score_valid,
  output logic                            score_ready,
  input  logic [DATA_WIDTH-1:0]           score_data,
  output logic [DATA_WIDTH*NUM_CLASS-1:0] layer_out,
  output logic                            cmp_valid,
  input  logic                            cmp_ready,
  input  logic [3:0]                      cmp_predict,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [3:0]                      out_class,
  output logic                            busy,
  output logic                            err
);

  localparam int CNT_W = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CLASS - 1);
  localparam logic [TMO_W-1:0] LAST_TMO = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_LAUNCH  = 3'd2,
    S_WAIT    = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [TMO_W-1:0] tmo;
  logic             accept;

  // A score word is taken only while collecting; score_ready is already
  // registered so this never depends combinationally on an output path.
  assign accept = (state == S_COLLECT) && score_valid && score_ready;

  // Score bus: slot cnt captures the accepted word; untouched slots and
  // aborted cycles keep their previous contents so the comparator sees a
  // stable bus through LAUNCH and WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      layer_out <= '0;
    end else if (accept && !abort) begin
      for (int k = 0; k < NUM_CLASS; k++) begin
        if (cnt == CNT_W'(k)) begin
          layer_out[k*DATA_WIDTH +: DATA_WIDTH] <= score_data;
        end
      end
    end
  end

  // Control FSM: all handshake and status outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      tmo         <= '0;
      cmp_valid   <= 1'b0;
      score_ready <= 1'b0;
      out_valid   <= 1'b0;
      out_class   <= 4'd0;
      busy        <= 1'b0;
      err         <= 1'b0;
    end else if (abort) begin
      // Abort wins over everything, including a simultaneous start.
      // err, out_class and layer_out are deliberately left untouched.
      state       <= S_IDLE;
      cnt         <= '0;
      tmo         <= '0;
      cmp_valid   <= 1'b0;
      score_ready <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_COLLECT;
            cnt         <= '0;
            err         <= 1'b0;
            score_ready <= 1'b1;
            busy        <= 1'b1;
          end
        end

        S_COLLECT: begin
          if (accept) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_CNT) begin
              // Final word: stop accepting and launch on the next cycle.
              state       <= S_LAUNCH;
              score_ready <= 1'b0;
              cmp_valid   <= 1'b1;
            end
          end
        end

        S_LAUNCH: begin
          cmp_valid <= 1'b0;
          tmo       <= '0;
          state     <= S_WAIT;
        end

        S_WAIT: begin
          tmo <= tmo + 1'b1;
          if (cmp_ready) begin
            out_class <= cmp_predict;
            out_valid <= 1'b1;
            state     <= S_HOLD;
          end else if (tmo == LAST_TMO) begin
            // Comparator never answered: flag and give up on this image.
            err   <= 1'b1;
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end

        S_HOLD: begin
          if (out_ready && out_valid) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
            busy      <= 1'b0;
          end
        end

        default: begin
          state       <= S_IDLE;
          cmp_valid   <= 1'b0;
          score_ready <= 1'b0;
          out_valid   <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
